// File: rtl/display_scan_capture_if.sv
// Bus bundle between the display scan tap (master) and display_scan_capture (slave).
interface display_scan_capture_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 sample_en;
    logic [3:0]           digit_select;
    logic [3:0]           cout;
    logic                 err_clr;
    logic [15:0]          value;
    logic                 value_valid;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 locked;

    modport master (
        output sample_en, digit_select, cout, err_clr,
        input  value, value_valid, frame_err, err_count, locked
    );

    modport slave (
        input  sample_en, digit_select, cout, err_clr,
        output value, value_valid, frame_err, err_count, locked
    );
endinterface

// File: rtl/display_scan_capture.sv
// Reassembles the 16-bit value shown on a 4-digit multiplexed display and flags scan-order errors.
// Optional: DISPLAY_CAPTURE_BLANK_EN treats digit_select 4'b1111 as a legal idle pattern.
//
// state   | meaning
// SYNC    | hunting for digit 0, not locked
// EXPECT0 | frame just completed, waiting for the next digit 0
// EXPECT1 | digit 0 captured, waiting for digit 1
// EXPECT2 | waiting for digit 2
// EXPECT3 | waiting for digit 3, which completes the frame
module display_scan_capture #(
    parameter int ERR_CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    display_scan_capture_if.slave bus
);
    typedef enum logic [2:0] {SYNC, EXPECT0, EXPECT1, EXPECT2, EXPECT3} state_t;

    state_t               state, state_nx;
    logic [15:0]          shadow, shadow_nx, value_q;
    logic                 valid_q, ferr_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 legal, blank;
    logic [1:0]           idx, cur;
    logic                 wr_en, done, err;

    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (bus.digit_select)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            4'b1110: idx = 2'd3;
            default: legal = 1'b0;
        endcase
`ifdef DISPLAY_CAPTURE_BLANK_EN
        blank = (bus.digit_select == 4'b1111);
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            EXPECT1: cur = 2'd1;
            EXPECT2: cur = 2'd2;
            EXPECT3: cur = 2'd3;
            default: cur = 2'd0;
        endcase
        if (bus.sample_en && !blank) begin
            case (state)
                SYNC: begin
                    if (!legal) begin
                        err = 1'b1;
                    end else if (idx == 2'd0) begin
                        wr_en    = 1'b1;
                        state_nx = EXPECT1;
                    end
                end
                EXPECT0: begin
                    if (legal && idx == 2'd0) begin
                        wr_en    = 1'b1;
                        state_nx = EXPECT1;
                    end else if (legal && idx == 2'd3) begin
                        wr_en = 1'b1;
                    end else begin
                        err      = 1'b1;
                        state_nx = SYNC;
                    end
                end
                default: begin
                    if (legal && idx == cur) begin
                        wr_en = 1'b1;
                        case (cur)
                            2'd1:    state_nx = EXPECT2;
                            2'd2:    state_nx = EXPECT3;
                            default: begin
                                done     = 1'b1;
                                state_nx = EXPECT0;
                            end
                        endcase
                    end else if (legal && idx == cur - 2'd1) begin
                        wr_en = 1'b1;
                    end else if (legal && idx == 2'd0) begin
                        // Early digit 0: the driver restarted its scan, so start a new frame here.
                        err      = 1'b1;
                        wr_en    = 1'b1;
                        state_nx = EXPECT1;
                    end else begin
                        err      = 1'b1;
                        state_nx = SYNC;
                    end
                end
            endcase
        end
    end

    always_comb begin
        shadow_nx = shadow;
        if (wr_en) begin
            case (idx)
                2'd0: shadow_nx[15:12] = bus.cout;
                2'd1: shadow_nx[11:8]  = bus.cout;
                2'd2: shadow_nx[7:4]   = bus.cout;
                2'd3: shadow_nx[3:0]   = bus.cout;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SYNC;
            shadow  <= 16'h0000;
            value_q <= 16'h0000;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state   <= state_nx;
            shadow  <= shadow_nx;
            valid_q <= done;
            ferr_q  <= err;
            if (done) begin
                value_q <= shadow_nx;
            end
            if (bus.err_clr) begin
                err_q <= '0;
            end else if (err && err_q != {ERR_CNT_W{1'b1}}) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.value_valid = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.err_count   = err_q;
    assign bus.locked      = (state != SYNC);
endmodule

// File: tb/tb_display_scan_capture.sv
// Scoreboard bench for display_scan_capture: directed scans from the plan plus randomized scan traffic.
module tb_display_scan_capture;
    localparam int EW = 2;
`ifdef DISPLAY_CAPTURE_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    display_scan_capture_if #(.ERR_CNT_W(EW)) bus ();
    display_scan_capture #(.ERR_CNT_W(EW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int value;
        int vv;
        int fe;
        int ec;
        int lk;
    } exp_t;

    exp_t cyc_q[$];
    int   val_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference: m_pos = -1 while hunting, else index of the digit expected next
    int m_pos = -1;
    int m_nib[4] = '{0, 0, 0, 0};
    int m_value = 0;
    int m_ec = 0;

    function automatic int decode(logic [3:0] ds);
        case (ds)
            4'b0111: return 0;
            4'b1011: return 1;
            4'b1101: return 2;
            4'b1110: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] sel_of(int d);
        logic [3:0] s;
        s = 4'b1111;
        s[3-d] = 1'b0;
        return s;
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit r, bit se, logic [3:0] ds, logic [3:0] c, bit clr);
        exp_t e;
        int   d;
        bit   ferr, vv;
        ferr = 1'b0;
        vv   = 1'b0;
        rst_n            = r;
        bus.sample_en    = se;
        bus.digit_select = ds;
        bus.cout         = c;
        bus.err_clr      = clr;
        @(posedge clk);
        if (!r) begin
            m_pos = -1;
            m_nib = '{0, 0, 0, 0};
            m_value = 0;
            m_ec = 0;
        end else begin
            d = decode(ds);
            if (se && !(BLANK && ds == 4'b1111)) begin
                if (m_pos < 0) begin
                    if (d < 0) ferr = 1'b1;
                    else if (d == 0) begin
                        m_nib[0] = int'(c);
                        m_pos = 1;
                    end
                end else if (d == m_pos) begin
                    m_nib[d] = int'(c);
                    if (m_pos == 3) begin
                        vv = 1'b1;
                        m_value = m_nib[0] * 4096 + m_nib[1] * 256 + m_nib[2] * 16 + m_nib[3];
                        m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end else if (d >= 0 && d == (m_pos + 3) % 4) begin
                    m_nib[d] = int'(c);
                end else if (d == 0) begin
                    ferr = 1'b1;
                    m_nib[0] = int'(c);
                    m_pos = 1;
                end else begin
                    ferr = 1'b1;
                    m_pos = -1;
                end
            end
            if (clr) m_ec = 0;
            else if (ferr && m_ec < (1 << EW) - 1) m_ec++;
        end
        if (vv) val_q.push_back(m_value);
        e.value = m_value;
        e.vv    = int'(vv);
        e.fe    = int'(ferr);
        e.ec    = m_ec;
        e.lk    = (m_pos >= 0) ? 1 : 0;
        cyc_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'b1111, 4'h0, 1'b0);
    endtask

    task automatic frame(logic [15:0] v, int gap);
        logic [15:0] w;
        w = v;
        for (int d = 0; d < 4; d++) begin
            step(1'b1, 1'b1, sel_of(d), w[15-4*d -: 4], 1'b0);
            idle(gap);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("value", int'(bus.value), e.value);
            check("value_valid", int'(bus.value_valid), e.vv);
            check("frame_err", int'(bus.frame_err), e.fe);
            check("err_count", int'(bus.err_count), e.ec);
            check("locked", int'(bus.locked), e.lk);
            if (bus.value_valid === 1'b1) begin
                if (val_q.size() == 0) check("unexpected_valid", 1, 0);
                else check("frame_value", int'(bus.value), val_q.pop_front());
            end
        end
    end

    initial begin
        int s;
        step(1'b0, 1'b0, 4'b1111, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'b0111, 4'h7, 1'b0);
        frame(16'h1234, 0);
        idle(2);
        for (int f = 0; f < 3; f++) frame(16'hBEEF, 3);
        step(1'b1, 1'b1, 4'b0111, 4'hB, 1'b0);
        step(1'b1, 1'b1, 4'b1101, 4'hE, 1'b0);
        frame(16'h00A5, 0);
        step(1'b1, 1'b0, 4'b1111, 4'h0, 1'b1);
        idle(1);
        step(1'b1, 1'b1, 4'b0011, 4'h1, 1'b0);
        step(1'b1, 1'b1, 4'b1111, 4'h2, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'b0000, 4'h3, 1'b0);
        step(1'b1, 1'b1, 4'b0101, 4'h4, 1'b1);
        step(1'b1, 1'b1, 4'b0111, 4'h5, 1'b0);
        step(1'b1, 1'b1, 4'b1011, 4'h6, 1'b0);
        step(1'b0, 1'b0, 4'b1111, 4'h0, 1'b0);
        frame(16'h9ABC, 1);
        frame(16'h1357, 0);
        step(1'b1, 1'b1, 4'b1110, 4'hF, 1'b0);
        step(1'b1, 1'b1, 4'b1011, 4'h1, 1'b0);
        s = 0;
        for (int i = 0; i < 600; i++) begin
            bit          se, clr, r;
            logic [3:0]  ds;
            se  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            r   = ($urandom_range(0, 150) != 0);
            case ($urandom_range(0, 19))
                0:       ds = 4'($urandom);
                1:       ds = 4'b1111;
                2:       ds = sel_of((s + 3) % 4);
                default: ds = sel_of(s);
            endcase
            if (se) s = (s + 1) % 4;
            step(r, se, ds, 4'($urandom), clr);
        end
        idle(3);
        check("pending_frames", val_q.size(), 0);
        check("pending_cycles", cyc_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
